// File: rtl/raiz_pkg.sv
// Shared definitions for the integer square-root core.
//   - state_e     : sequencer states
//   - WIDTH_DEF   : default operand width (even, >= 4)
//   - ITER_DEF    : iterations for the default width (two result bits each)
//   - cnt_width() : iteration-counter width for a given iteration count
package raiz_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int ITER_DEF  = WIDTH_DEF / 2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    TEST,
    FIN
  } state_e;

  // $clog2(1) is 0, so keep at least one counter bit.
  function automatic int cnt_width(input int iter);
    return (iter > 1) ? $clog2(iter) : 1;
  endfunction

  localparam int CNT_W_DEF = cnt_width(ITER_DEF);

endpackage

// File: rtl/raiz_trial_sub.sv
// Trial subtraction for one restoring square-root iteration.
//   a_in    in  WIDTH    partial remainder after the 2-bit shift
//   root_in in  WIDTH/2  root bits found so far
//   sum_c2  out WIDTH    a_in - {root_in, 2'b01}, two's complement
//   msb     out 1        sign of sum_c2 (1 = trial value too large)
// The partial remainder never exceeds 2*root, so after the shift it stays
// below 2^(WIDTH/2+3) and the WIDTH-bit result's sign bit is exact.
module raiz_trial_sub
  import raiz_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH/2-1:0] root_in,
  output logic [WIDTH-1:0]   sum_c2,
  output logic               msb
);

  logic [WIDTH-1:0] trial;

  always_comb begin
    trial  = WIDTH'({root_in, 2'b01});
    sum_c2 = a_in + ~trial + WIDTH'(1);
    msb    = sum_c2[WIDTH-1];
  end

endmodule

// File: rtl/raiz_control_unit.sv
// Sequencer and root datapath of the integer square-root core.
// Drives the external A/remainder shift register and accumulates the root,
// one root bit per SHIFT/TEST pair, WIDTH/2 pairs per operand.
//   CLK    in  1        clock, rising edge
//   RST    in  1        synchronous active-high reset
//   START  in  1        run request, honoured only in IDLE
//   A_out  in  WIDTH    partial remainder from the A register
//   LD     out 1        load strobe (A cleared, operand shadow loaded)
//   SH     out 1        shift-by-2 strobe
//   LDA2   out 1        conditional-load strobe (A takes SUM_C2 when MSB=0)
//   MSB    out 1        sign of SUM_C2
//   SUM_C2 out WIDTH    A_out - {ROOT, 2'b01}
//   ROOT   out WIDTH/2  root register, held after completion
//   BUSY   out 1        high from LOAD through the last TEST
//   DONE   out 1        one-cycle completion pulse
module raiz_control_unit
  import raiz_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  input  logic [WIDTH-1:0]   A_out,
  output logic               LD,
  output logic               SH,
  output logic               LDA2,
  output logic               MSB,
  output logic [WIDTH-1:0]   SUM_C2,
  output logic [WIDTH/2-1:0] ROOT,
  output logic               BUSY,
  output logic               DONE
);

  localparam int ITER  = WIDTH / 2;
  localparam int RW    = WIDTH / 2;
  localparam int CNT_W = cnt_width(ITER);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  state_e           state_q, state_d;
  logic [RW-1:0]    root_q, root_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  raiz_trial_sub #(
    .WIDTH(WIDTH)
  ) u_trial (
    .a_in   (A_out),
    .root_in(root_q),
    .sum_c2 (SUM_C2),
    .msb    (MSB)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      root_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      root_q  <= root_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    root_d  = root_q;
    cnt_d   = cnt_q;
    LD      = 1'b0;
    SH      = 1'b0;
    LDA2    = 1'b0;
    BUSY    = 1'b0;
    DONE    = 1'b0;
    case (state_q)
      IDLE: begin
        if (START) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        LD      = 1'b1;
        BUSY    = 1'b1;
        root_d  = '0;
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        SH      = 1'b1;
        BUSY    = 1'b1;
        state_d = TEST;
      end
      TEST: begin
        LDA2   = 1'b1;
        BUSY   = 1'b1;
        // A non-negative trial result means the new root bit is 1; the A
        // register commits SUM_C2 on this same edge in that case.
        root_d = {root_q[RW-2:0], ~MSB};
        if (cnt_q == CNT_LAST) begin
          state_d = FIN;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = SHIFT;
        end
      end
      FIN: begin
        DONE    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ROOT = root_q;

endmodule

// File: tb/tb_raiz_control_unit.sv
module tb_raiz_control_unit;

  localparam int W = 16;

  logic          CLK = 1'b0;
  logic          RST;
  logic          START;
  logic [W-1:0]  A_out;
  logic          LD, SH, LDA2, MSB, BUSY, DONE;
  logic [W-1:0]  SUM_C2;
  logic [W/2-1:0] ROOT;

  int errors = 0;
  int checks = 0;

  // Environment: behavioural A/remainder register with operand shadow.
  logic [W-1:0] a_reg;
  logic [W-1:0] tmp_reg;
  logic [W-1:0] op_a;

  assign A_out = a_reg;

  raiz_control_unit #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
    .A_out (A_out),
    .LD    (LD),
    .SH    (SH),
    .LDA2  (LDA2),
    .MSB   (MSB),
    .SUM_C2(SUM_C2),
    .ROOT  (ROOT),
    .BUSY  (BUSY),
    .DONE  (DONE)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (LD) begin
      a_reg   <= '0;
      tmp_reg <= op_a;
    end else if (SH) begin
      {a_reg, tmp_reg} <= {a_reg, tmp_reg} << 2;
    end else if (LDA2 && !MSB) begin
      a_reg <= SUM_C2;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int isqrt(input int x);
    for (int r = 255; r >= 0; r--) begin
      if (r * r <= x) return r;
    end
    return 0;
  endfunction

  // Follows one run from the cycle after the accepting edge up to DONE.
  // Cycle c (1-based): 1 = LOAD, even 2..16 = SHIFT, odd 3..17 = TEST, 18 = FIN.
  task automatic wait_done(input logic [W-1:0] op, input string tag);
    int c = 0;
    bit seen = 0;
    int seq_err = 0;
    logic [2:0] code, exp_code;
    int r;
    while (!seen && c < 40) begin
      @(negedge CLK);
      c++;
      code = {LDA2, SH, LD};
      if (c == 1)       exp_code = 3'b001;
      else if (c <= 17) exp_code = (c % 2 == 0) ? 3'b010 : 3'b100;
      else              exp_code = 3'b000;
      if (code !== exp_code) seq_err++;
      if (BUSY !== (c <= 17)) seq_err++;
      if (DONE === 1'b1) seen = 1;
    end
    r = isqrt(int'(op));
    check({tag, " latency"}, c, 18);
    check({tag, " strobe_seq"}, seq_err, 0);
    check({tag, " root"}, ROOT, r);
    check({tag, " remainder"}, a_reg, int'(op) - r * r);
    check({tag, " rem_bound"}, 32'(a_reg <= 2 * ROOT), 1);
    $display("op=%0d root=%0d rem=%0d cycles=%0d", op, ROOT, a_reg, c);
  endtask

  task automatic run_op(input logic [W-1:0] op, input bit hold, input string tag);
    op_a = op;
    @(negedge CLK);
    START = 1'b1;
    @(posedge CLK);
    #1;
    if (!hold) START = 1'b0;
    wait_done(op, tag);
  endtask

  initial begin
    int n;
    logic [W-1:0] rop;
    a_reg   = '0;
    tmp_reg = '0;
    op_a    = '0;
    RST     = 1'b1;
    START   = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("reset strobes", {LD, SH, LDA2, BUSY, DONE}, 0);
    check("reset root", ROOT, 0);
    RST = 1'b0;

    run_op(16'd0, 0, "op0");
    check("op0 a_out", a_reg, 0);
    run_op(16'd144, 0, "op144");
    run_op(16'd200, 0, "op200");
    run_op(16'd1, 0, "op1");
    run_op(16'd65535, 0, "op65535");

    // START held through a whole run and the FIN cycle.
    run_op(16'd144, 1, "hold1");
    op_a = 16'd200;
    @(negedge CLK);
    check("hold idle LD", LD, 0);
    check("hold idle BUSY", BUSY, 0);
    check("hold done pulse", DONE, 0);
    check("hold root kept", ROOT, 12);
    @(posedge CLK);
    #1;
    START = 1'b0;
    wait_done(16'd200, "hold2");

    // Reset during the 5th TEST cycle.
    op_a = 16'd50000;
    @(negedge CLK);
    START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    n = 0;
    for (int c = 0; c < 30 && n < 5; c++) begin
      @(negedge CLK);
      if (LDA2 === 1'b1) n++;
    end
    check("rst reached 5th test", n, 5);
    RST = 1'b1;
    @(negedge CLK);
    check("rst strobes", {LD, SH, LDA2, BUSY, DONE}, 0);
    check("rst root", ROOT, 0);
    RST = 1'b0;
    @(negedge CLK);
    check("rst stays idle", {LD, SH, LDA2, BUSY, DONE}, 0);
    run_op(16'd81, 0, "op81");

    for (int i = 0; i < 1000; i++) begin
      rop = W'($urandom_range(0, 65535));
      run_op(rop, 0, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/raiz_control_unit.md
# raiz_control_unit

Sequencer and root datapath for the integer square-root core; sits directly upstream of the A/remainder shift register (LSR_A_RAIZ-style, fixed 16-bit). It drives that register's LD/SH/LDA2 strobes, computes the trial subtraction SUM_C2 and its sign MSB from the register's A_out, and accumulates the root. The root is computed by the restoring two-bits-per-iteration method: 8 iterations for a 16-bit operand.

## Interface
- WIDTH, 16, operand width; even, ≥4; ITER = WIDTH/2 iterations; root width WIDTH/2.
- CLK  in  1  clock, all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  request; sampled only in IDLE.
- A_out  in  WIDTH  current A register value (partial remainder).
- LD  out  WIDTH-independent 1  load strobe to A register (clears A, loads operand shadow).
- SH  out  1  shift-by-2 strobe to A register.
- LDA2  out  1  conditional-load strobe to A register.
- MSB  out  1  sign of SUM_C2; A register loads only when 0.
- SUM_C2  out  WIDTH  A_out − {ROOT, 2'b01}, two's complement.
- ROOT  out  WIDTH/2  root register.
- BUSY  out  1  high from LOAD through last TEST.
- DONE  out  1  one-cycle pulse; ROOT and A_out (remainder) valid.

## Operation
- States: IDLE, LOAD, SHIFT, TEST, FIN.
- IDLE: all strobes 0; START=1 → LOAD.
- LOAD: LD=1; ROOT←0; iteration counter←0 → SHIFT.
- SHIFT: SH=1 (A register shifts {A,TMP} left 2) → TEST.
- TEST: LDA2=1; SUM_C2 = A_out + ~{ROOT,2'b01} + 1 (WIDTH bits, root zero-extended); MSB = SUM_C2[WIDTH-1]. ROOT←{ROOT[WIDTH/2-2:0], ~MSB}. Counter = ITER−1 → FIN, else counter+1 → SHIFT.
- FIN: DONE=1, BUSY=0 → IDLE unconditionally.
- SUM_C2/MSB are combinational from A_out and ROOT in every state; only meaningful in TEST.
- Width rule: partial remainder ≤ 2·ROOT, so after shift A < 2^(WIDTH/2+3); sign bit of WIDTH-bit result is exact for WIDTH ≥ 4, no extra guard bit.
- ROOT holds its value after FIN until next LOAD.
- START outside IDLE (including FIN cycle) ignored, not queued.
- Reset values: state IDLE, ROOT 0, counter 0, LD/SH/LDA2/BUSY/DONE 0.
- RST mid-operation: RST overrides everything, returns to IDLE next edge; A register is not reset by this block—next START's LOAD reinitialises it.
- At most one of LD/SH/LDA2 high in any cycle.

## Timing
- START high at edge k (IDLE) → LOAD during cycle k+1.
- Iteration i (0..ITER−1): SHIFT at k+2+2i, TEST at k+3+2i.
- WIDTH=16: last TEST at k+17, DONE pulse at k+18; next START accepted at edge k+19 earliest.
- Total latency START→DONE: 2·ITER+2 cycles; throughput one root per 2·ITER+3 cycles.
- A register samples strobes on the same edge this block advances state; MSB in TEST derives from A_out post-shift.

## Structure
- Shared package raiz_pkg: state enum (IDLE, LOAD, SHIFT, TEST, FIN), WIDTH default, ITER = WIDTH/2, counter width $clog2(ITER).
- Sub-module raiz_trial_sub: combinational A_out − {ROOT,01} → SUM_C2, MSB; reused by any future wider root variant.
- FSM, counter and ROOT register in the top module; integration test wires it to the A register.

## Test plan
- Op_A=0, START pulse → DONE at k+18, ROOT=0, A_out=0; strobe sequence LD, (SH,LDA2)×8 exactly.
- Op_A=144 → ROOT=12, remainder 0; Op_A=200 → ROOT=14, remainder 4; Op_A=1 → ROOT=1, remainder 0.
- Op_A=65535 → ROOT=255, remainder 510 (max-width check, MSB never mis-signed).
- START held high through whole run → exactly one run, then new run starting edge after FIN (START at FIN ignored).
- RST asserted at the 5th TEST cycle → next cycle IDLE, all outputs 0, ROOT=0; fresh START with Op_A=81 → ROOT=9, remainder 0.
- Random 1000 operands vs. floor(sqrt) reference: ROOT²+rem = Op_A, rem ≤ 2·ROOT.
